// File: rtl/npu_quant_pkg.sv
// Shared quantization package: int32 limits, exponent range, table entry type,
// int32 saturation and exponent clamp helpers.
package npu_quant_pkg;

    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
    localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [5:0]  SHIFT_MIN = -6'sd31;
    localparam logic signed [5:0]  SHIFT_MAX = 6'sd30;

    // One per-channel table entry: quantized multiplier and signed exponent.
    typedef struct packed {
        logic signed [31:0] mult;
        logic signed [5:0]  shift;
    } qentry_t;

    // Saturate a 64-bit signed value into int32.
    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        logic signed [31:0] r;
        if (v > 64'(INT32_MAX)) begin
            r = INT32_MAX;
        end else if (v < 64'(INT32_MIN)) begin
            r = INT32_MIN;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

    // Clamp a written exponent into the supported range.
    function automatic logic signed [5:0] clamp_shift(input logic signed [5:0] s);
        logic signed [5:0] r;
        if (s < SHIFT_MIN) begin
            r = SHIFT_MIN;
        end else if (s > SHIFT_MAX) begin
            r = SHIFT_MAX;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/requant_pipeline_pc_if.sv
// Requantizer bus: config write port, quasi-static output params,
// input beat channel and output beat channel (valid/ready).
// master = producer/consumer side, slave = requantizer side.
interface requant_pipeline_pc_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned CH_NUM = 64
);
    localparam int unsigned CH_W = $clog2(CH_NUM);

    logic                       cfg_we;
    logic [CH_W-1:0]            cfg_addr;
    logic signed [31:0]         cfg_mult;
    logic signed [5:0]          cfg_shift;
    logic                       per_channel;
    logic signed [OUT_W-1:0]    out_zp;
    logic signed [OUT_W-1:0]    act_min;
    logic signed [OUT_W-1:0]    act_max;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*32-1:0]        in_data;
    logic [CH_W-1:0]            in_ch;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*OUT_W-1:0]     out_data;

    modport master (
        output cfg_we, cfg_addr, cfg_mult, cfg_shift, per_channel,
               out_zp, act_min, act_max, in_valid, in_data, in_ch, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_mult, cfg_shift, per_channel,
               out_zp, act_min, act_max, in_valid, in_data, in_ch, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/requant_lane.sv
// One requantizer lane, 4 stages advancing on en_i:
//   S0 left shift (sat), S1 32x32 multiply, S2 nudge/high word/overflow,
//   S3 rounding divide, zero point, clamp.
// Ports: clk, rst (async active-low), en_i, x_i accumulator, ent_i table
// entry, zp_i/min_i/max_i output params, y_o registered result.
module requant_lane
    import npu_quant_pkg::*;
#(
    parameter int unsigned OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic signed [31:0]      x_i,
    input  qentry_t                 ent_i,
    input  logic signed [OUT_W-1:0] zp_i,
    input  logic signed [OUT_W-1:0] min_i,
    input  logic signed [OUT_W-1:0] max_i,
    output logic signed [OUT_W-1:0] y_o
);
    localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
    localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;
    localparam logic signed [63:0] TRUNC_ADJ = 64'sd2147483647;

    logic [4:0]              l_d, r0_d;
    logic signed [63:0]      xw_d;
    logic signed [31:0]      xs_d, xs_q, m_q;
    logic [4:0]              r0_q, r1_q, r2_q;
    logic signed [63:0]      xa_d, ma_d, p_d, p_q, sum_d, hw_d;
    logic                    ovf_d, ovf_q;
    logic signed [31:0]      h_d, h_q, sh_d, q_d, y32_d, mn_d, mx_d, yc_d;
    logic [31:0]             mask_d, rem_d, thr_d;
    logic signed [32:0]      zs_d;
    logic signed [OUT_W-1:0] y_q;

    // S0: split exponent into left/right amounts, saturating left shift
    always_comb begin
        l_d  = '0;
        r0_d = '0;
        if (ent_i.shift[5]) begin
            r0_d = 5'(-ent_i.shift);
        end else begin
            l_d = ent_i.shift[4:0];
        end
        xw_d = {{32{x_i[31]}}, x_i};
        xs_d = sat32(xw_d <<< l_d);
    end

    // S1: full signed product plus the single overflow case
    always_comb begin
        xa_d  = {{32{xs_q[31]}}, xs_q};
        ma_d  = {{32{m_q[31]}}, m_q};
        p_d   = xa_d * ma_d;
        ovf_d = (xs_q == INT32_MIN) && (m_q == INT32_MIN);
    end

    // S2: nudge, divide by 2^31 truncating toward zero
    always_comb begin
        sum_d = p_q + (p_q[63] ? NUDGE_NEG : NUDGE_POS);
        hw_d  = sum_d[63] ? ((sum_d + TRUNC_ADJ) >>> 31) : (sum_d >>> 31);
        h_d   = ovf_q ? INT32_MAX : hw_d[31:0];
    end

    // S3: round-half-away divide by 2^R, add zero point, clamp
    always_comb begin
        mask_d = 32'((33'd1 << r2_q) - 33'd1);
        rem_d  = h_q & mask_d;
        thr_d  = (mask_d >> 1) + {31'd0, h_q[31]};
        sh_d   = h_q >>> r2_q;
        q_d    = sh_d + 32'(rem_d > thr_d);
        zs_d   = {q_d[31], q_d} + {{(33-OUT_W){zp_i[OUT_W-1]}}, zp_i};
        y32_d  = sat32({{31{zs_d[32]}}, zs_d});
        mn_d   = {{(32-OUT_W){min_i[OUT_W-1]}}, min_i};
        mx_d   = {{(32-OUT_W){max_i[OUT_W-1]}}, max_i};
        yc_d   = y32_d;
        if (y32_d < mn_d) begin
            yc_d = mn_d;
        end else if (y32_d > mx_d) begin
            yc_d = mx_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xs_q  <= '0;
            m_q   <= '0;
            r0_q  <= '0;
            p_q   <= '0;
            ovf_q <= 1'b0;
            r1_q  <= '0;
            h_q   <= '0;
            r2_q  <= '0;
            y_q   <= '0;
        end else if (en_i) begin
            xs_q  <= xs_d;
            m_q   <= ent_i.mult;
            r0_q  <= r0_d;
            p_q   <= p_d;
            ovf_q <= ovf_d;
            r1_q  <= r0_q;
            h_q   <= h_d;
            r2_q  <= r1_q;
            y_q   <= yc_d[OUT_W-1:0];
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/requant_pipeline_pc.sv
// Multi-lane per-channel requantizer: int32 accumulators -> OUT_W-bit
// activations. Owns the multiplier/shift table, its registered per-lane read,
// the valid chain and the global-stall handshake.
// Ports: clk, rst (async active-low), bus (slave side of the requant bus).
module requant_pipeline_pc
    import npu_quant_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned CH_NUM = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    requant_pipeline_pc_if.slave bus
);
    localparam int unsigned CH_W = $clog2(CH_NUM);
    localparam int unsigned IW   = CH_W + 1;
    localparam int unsigned NSTG = 5;

    logic                    en_c, accept_c;
    qentry_t                 tbl_q [CH_NUM];
    qentry_t                 ent_q [LANES];
    logic signed [31:0]      x_q [LANES];
    logic [IW-1:0]           rd_sum_c [LANES];
    logic [CH_W-1:0]         rd_idx_c [LANES];
    logic [NSTG-1:0]         v_q;
    logic signed [OUT_W-1:0] y_c [LANES];

    // Whole pipeline stalls only while an output is waiting for the consumer
    assign en_c         = !v_q[NSTG-1] || bus.out_ready;
    assign accept_c     = bus.in_valid && en_c;
    assign bus.in_ready = en_c;
    assign bus.out_valid = v_q[NSTG-1];

    // Lane k reads (in_ch + k) mod CH_NUM; sum stays below 2*CH_NUM
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rd_sum_c[k] = IW'(bus.in_ch) + IW'(k % CH_NUM);
            if (rd_sum_c[k] >= IW'(CH_NUM)) begin
                rd_sum_c[k] = rd_sum_c[k] - IW'(CH_NUM);
            end
            rd_idx_c[k] = bus.per_channel ? CH_W'(rd_sum_c[k]) : '0;
        end
    end

    // Table write; a same-edge read in the read stage still sees the old entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH_NUM; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            tbl_q[bus.cfg_addr] <= '{mult: bus.cfg_mult, shift: clamp_shift(bus.cfg_shift)};
        end
    end

    // Registered table read and accumulator capture, plus valid chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                ent_q[k] <= '0;
                x_q[k]   <= '0;
            end
        end else if (en_c) begin
            v_q <= {v_q[NSTG-2:0], accept_c};
            for (int k = 0; k < LANES; k++) begin
                ent_q[k] <= tbl_q[rd_idx_c[k]];
                x_q[k]   <= bus.in_data[k*32 +: 32];
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        requant_lane #(.OUT_W(OUT_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en_i  (en_c),
            .x_i   (x_q[k]),
            .ent_i (ent_q[k]),
            .zp_i  (bus.out_zp),
            .min_i (bus.act_min),
            .max_i (bus.act_max),
            .y_o   (y_c[k])
        );
        assign bus.out_data[k*OUT_W +: OUT_W] = y_c[k];
    end

endmodule

// File: tb/tb_requant_pipeline_pc.sv
// Directed bench for requant_pipeline_pc with a scoreboard queue of expected
// output beats and a reference arithmetic model of the requantizer.
module tb_requant_pipeline_pc;
    localparam int unsigned LANES  = 4;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned CH_NUM = 64;
    localparam int unsigned CH_W   = 6;

    localparam longint L_MIN = -64'sd2147483648;
    localparam longint L_MAX = 64'sd2147483647;
    localparam longint TWO30 = 64'sd1073741824;
    localparam longint TWO31 = 64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    requant_pipeline_pc_if #(.LANES(LANES), .OUT_W(OUT_W), .CH_NUM(CH_NUM)) bus ();

    requant_pipeline_pc #(.LANES(LANES), .OUT_W(OUT_W), .CH_NUM(CH_NUM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic [LANES*OUT_W-1:0] exp_q [$];
    longint mdl_m [CH_NUM];
    int     mdl_s [CH_NUM];
    logic   hold_pend = 1'b0;
    logic [LANES*OUT_W-1:0] hold_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic longint model_lane(input longint x, input longint m, input int s,
                                          input longint zp, input longint mn, input longint mx);
        longint xs, p, h, q, y, mask, rem, thr;
        int l, r;
        l = (s > 0) ? s : 0;
        r = (s < 0) ? -s : 0;
        xs = x * (longint'(1) << l);
        if (xs > L_MAX) xs = L_MAX;
        if (xs < L_MIN) xs = L_MIN;
        if (xs == L_MIN && m == L_MIN) begin
            h = L_MAX;
        end else begin
            p = xs * m;
            h = (p + ((p >= 0) ? TWO30 : (1 - TWO30))) / TWO31;
        end
        mask = (longint'(1) << r) - 1;
        rem  = h & mask;
        thr  = (mask >>> 1) + ((h < 0) ? 1 : 0);
        q    = (h >>> r) + ((rem > thr) ? 1 : 0);
        y    = q + zp;
        if (y > L_MAX) y = L_MAX;
        if (y < L_MIN) y = L_MIN;
        if (y < mn) y = mn;
        else if (y > mx) y = mx;
        return y;
    endfunction

    function automatic logic [LANES*32-1:0] px(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [LANES*OUT_W-1:0] py(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic void model_write(input int addr, input longint m, input int s);
        logic signed [31:0] m32;
        m32 = 32'(m);
        mdl_m[addr] = longint'(m32);
        mdl_s[addr] = (s < -31) ? -31 : ((s > 30) ? 30 : s);
    endfunction

    task automatic cfg_write(input int addr, input longint m, input int s);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = CH_W'(addr);
        bus.cfg_mult  = 32'(m);
        bus.cfg_shift = 6'(s);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        model_write(addr, m, s);
    endtask

    // Drive one beat, wait for acceptance, push the expected result
    task automatic send(input logic [LANES*32-1:0] data, input int ch, input logic pc,
                        input bit use_fixed, input logic [LANES*OUT_W-1:0] fixed);
        logic [LANES*OUT_W-1:0] e;
        logic signed [31:0] xl;
        longint y;
        int idx;
        int n;
        bus.in_data     = data;
        bus.in_ch       = CH_W'(ch);
        bus.per_channel = pc;
        bus.in_valid    = 1'b1;
        #2;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #3;
            n++;
        end
        if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'd1);
        e = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = pc ? ((ch + k) % CH_NUM) : 0;
            xl  = data[k*32 +: 32];
            y   = model_lane(longint'(xl), mdl_m[idx], mdl_s[idx], longint'(bus.out_zp),
                             longint'(bus.act_min), longint'(bus.act_max));
            e[k*OUT_W +: OUT_W] = OUT_W'(y);
        end
        exp_q.push_back(use_fixed ? fixed : e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: scoreboard pop on transfer, hold check under backpressure
    always @(negedge clk) begin
        if (rst) begin
            if (hold_pend) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(hold_data));
            end
            hold_pend = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                hold_pend = 1'b1;
                hold_data = bus.out_data;
            end
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        int k;
        bus.cfg_we = 1'b0;  bus.cfg_addr = '0; bus.cfg_mult = '0; bus.cfg_shift = '0;
        bus.per_channel = 1'b0; bus.out_zp = '0; bus.act_min = -8'sd128; bus.act_max = 8'sd127;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ch = '0; bus.out_ready = 1'b1;
        for (int i = 0; i < CH_NUM; i++) begin
            mdl_m[i] = 0;
            mdl_s[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic scaling with negative zero point, then saturation at zp=0
        bus.out_zp = -8'sd3;
        cfg_write(0, 64'h4000_0000, 0);
        send(px(100, -100, 0, 1024), 0, 1'b0, 1'b1, py(47, -53, -3, 127));
        drain("drain_zp_m3");
        bus.out_zp = 8'sd0;
        send(px(1024, 100, 5, -5), 0, 1'b0, 1'b1, py(127, 50, 3, -2));

        // Rounding divide, S=-1 then S=3
        cfg_write(0, 64'h4000_0000, -1);
        send(px(5, -5, 4, -4), 0, 1'b0, 1'b1, py(2, -1, 1, -1));
        cfg_write(0, 64'h4000_0000, 3);
        send(px(-26, 26, 1, 0), 0, 1'b0, 1'b1, py(-104, 104, 4, 0));

        // INT32_MIN x INT32_MIN overflow path, large right shift
        cfg_write(0, 64'h8000_0000, -24);
        send(px(32'h8000_0000, 0, 32'h7FFF_FFFF, -256), 0, 1'b0, 1'b1, py(127, 0, -128, 0));

        // Exponent -32 clamps to -31 on write
        cfg_write(0, 64'h7FFF_FFFF, -32);
        send(px(32'h7FFF_FFFF, 0, 0, 0), 0, 1'b0, 1'b1, py(1, 0, 0, 0));
        drain("drain_arith");

        // Activation clamp window with zero point
        bus.out_zp = 8'sd5; bus.act_min = -8'sd10; bus.act_max = 8'sd20;
        cfg_write(0, 64'h4000_0000, 0);
        send(px(100, -100, 0, 20), 0, 1'b0, 1'b1, py(20, -10, 5, 15));
        drain("drain_clamp");
        bus.out_zp = 8'sd0; bus.act_min = -8'sd128; bus.act_max = 8'sd127;

        // Per-channel wraparound: lanes read 62, 63, 0, 1
        cfg_write(62, 64'h4000_0000, 0);
        cfg_write(63, 64'h4000_0000, 1);
        cfg_write(0, 64'h4000_0000, 2);
        cfg_write(1, 64'h4000_0000, -1);
        send(px(20, 20, 20, 20), 62, 1'b1, 1'b1, py(10, 20, 40, 5));
        send(px(20, 20, 20, 20), 62, 1'b0, 1'b1, py(40, 40, 40, 40));

        // Config write on the accept edge: that beat sees the old entry
        bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_mult = 32'h2000_0000; bus.cfg_shift = 6'd2;
        send(px(20, 20, 20, 20), 0, 1'b0, 1'b1, py(40, 40, 40, 40));
        bus.cfg_we = 1'b0;
        model_write(0, 64'h2000_0000, 2);
        send(px(20, 20, 20, 20), 0, 1'b0, 1'b1, py(20, 20, 20, 20));
        drain("drain_perch");

        // Random table entries and beats against the model
        for (int i = 0; i < 10; i++) begin
            k = $urandom_range(0, CH_NUM - 1);
            cfg_write(k, longint'($urandom), int'($urandom_range(0, 63)) - 32);
            send(px(int'($urandom), int'($urandom_range(0, 4000)) - 2000,
                    int'($urandom) >>> 8, int'($urandom_range(0, 255)) - 128),
                 int'($urandom_range(0, CH_NUM - 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
        end
        drain("drain_random");

        // Backpressure: 16 beats back-to-back, consumer stalls 5 cycles
        cfg_write(0, 64'h4000_0000, 0);
        cnt0 = out_cnt;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(px(i * 8, i * 8 + 2, -(i * 8) - 4, i * 8 + 6), 0, 1'b0, 1'b0, '0);
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                #2;
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_bp");
        check("bp_count", 64'(out_cnt - cnt0), 64'd16);

        // Reset with three beats in flight
        send(px(1, 2, 3, 4), 0, 1'b0, 1'b0, '0);
        send(px(5, 6, 7, 8), 0, 1'b0, 1'b0, '0);
        send(px(9, 10, 11, 12), 0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_data", 64'(bus.out_data), 64'd0);
        exp_q.delete();
        for (int i = 0; i < CH_NUM; i++) begin
            mdl_m[i] = 0;
            mdl_s[i] = 0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.out_zp = 8'sd7;
        cnt0 = out_cnt;
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_beat", 64'(out_cnt - cnt0), 64'd0);
        send(px(1000, -5, 3, 9), 0, 1'b1, 1'b1, py(7, 7, 7, 7));
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("post_rst_latency", 64'(k), 64'd4);
        drain("drain_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
